// File: rtl/cbd_mod_cnt_if.sv
// Count-control and status bundle for cbd_mod_cnt.
// When CBD_MOD_CNT_UPDN_EN is defined, the bundle also carries the UP direction select.
interface cbd_mod_cnt_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             CAI;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             CAO;
    logic             UNF;
`ifdef CBD_MOD_CNT_UPDN_EN
    logic             UP;

    modport master (output EN, CAI, LD, D, UP, input Q, CAO, UNF);
    modport slave  (input EN, CAI, LD, D, UP, output Q, CAO, UNF);
`else
    modport master (output EN, CAI, LD, D, input Q, CAO, UNF);
    modport slave  (input EN, CAI, LD, D, output Q, CAO, UNF);
`endif
endinterface

// File: rtl/cbd_mod_cnt.sv
// Cascadable modulo-MODULUS down counter with load, combinational carry-out and sticky underflow.
// Defining CBD_MOD_CNT_UPDN_EN adds the UP input, which selects up-counting.
module cbd_mod_cnt #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16,
    parameter longint unsigned RST_VAL = 0
) (
    input logic          CLK,
    input logic          CDN,
    cbd_mod_cnt_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cbd_mod_cnt: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("cbd_mod_cnt: MODULUS must be 2..2**WIDTH");
    end
    if (RST_VAL >= MODULUS) begin : g_bad_rst_val
        $error("cbd_mod_cnt: RST_VAL must be below MODULUS");
    end

    // MODULUS-1 always fits in WIDTH bits, so every compare is done against it.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             unf_r;
    logic             unf_nxt;
    logic             up;
    logic             step;
    logic             at_end;

`ifdef CBD_MOD_CNT_UPDN_EN
    assign up = bus.UP;
`else
    assign up = 1'b0;
`endif

    assign step   = bus.CAI && bus.EN;
    assign at_end = up ? (q_r == MAX_Q) : (q_r == '0);

    always_comb begin
        q_nxt   = q_r;
        unf_nxt = unf_r;
        if (bus.LD) begin
            q_nxt   = (bus.D > MAX_Q) ? MAX_Q : bus.D;
            unf_nxt = 1'b0;
        end else if (step) begin
            if (at_end) begin
                q_nxt   = up ? '0 : MAX_Q;
                unf_nxt = 1'b1;
            end else begin
                q_nxt   = up ? (q_r + ONE) : (q_r - ONE);
            end
        end
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            q_r   <= RST_Q;
            unf_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            unf_r <= unf_nxt;
        end
    end

    // The borrow is combinational so that a chain of stages ripples within one cycle.
    assign bus.CAO = CDN && step && !bus.LD && at_end;
    assign bus.Q   = q_r;
    assign bus.UNF = unf_r;

endmodule

// File: tb/tb_cbd_mod_cnt.sv
// Directed bench for cbd_mod_cnt (WIDTH=4, MODULUS=10), including a two-stage decade cascade.
module tb_cbd_mod_cnt;

   logic CLK = 1'b0;
   logic CDN;
   int   checks   = 0;
   int   failures = 0;
   int   exp_val;
   int   got_val;

   cbd_mod_cnt_if #(.WIDTH(4)) if0 ();
   cbd_mod_cnt_if #(.WIDTH(4)) if1 ();

   assign if1.CAI = if0.CAO;

   cbd_mod_cnt #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_stage0 (
      .CLK (CLK),
      .CDN (CDN),
      .bus (if0.slave)
   );

   cbd_mod_cnt #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_stage1 (
      .CLK (CLK),
      .CDN (CDN),
      .bus (if1.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load0(input logic [3:0] d);
      if0.LD = 1'b1;
      if0.D  = d;
      tick();
      if0.LD = 1'b0;
   endtask

   initial begin
      CDN = 1'b0;
      if0.EN = 1'b0; if0.CAI = 1'b0; if0.LD = 1'b0; if0.D = '0;
      if1.EN = 1'b0; if1.LD = 1'b0; if1.D = '0;
`ifdef CBD_MOD_CNT_UPDN_EN
      if0.UP = 1'b0;
      if1.UP = 1'b0;
`endif
      #12;
      chk("reset_q", if0.Q, 4'd0);
      chk("reset_unf", if0.UNF, 1'b0);
      chk("reset_cao", if0.CAO, 1'b0);
      CDN = 1'b1;
      tick();

      // Build up Q=7 with UNF set, then clear asynchronously mid-count.
      load0(4'd0);
      if0.CAI = 1'b1; if0.EN = 1'b1;
      tick(); tick(); tick();
      chk("precount_q", if0.Q, 4'd7);
      chk("precount_unf", if0.UNF, 1'b1);
      #3;
      CDN = 1'b0;
      #1;
      chk("async_clr_q", if0.Q, 4'd0);
      chk("async_clr_unf", if0.UNF, 1'b0);
      chk("async_clr_cao", if0.CAO, 1'b0);
      if0.CAI = 1'b0; if0.EN = 1'b0;
      #1;
      CDN = 1'b1;
      tick(); tick(); tick();
      chk("post_reset_hold_q", if0.Q, 4'd0);

      // Wrap: 2,1,0,9,8.
      load0(4'd2);
      chk("wrap_q0", if0.Q, 4'd2);
      if0.CAI = 1'b1; if0.EN = 1'b1;
      #1;
      chk("wrap_cao_at2", if0.CAO, 1'b0);
      tick();
      chk("wrap_q1", if0.Q, 4'd1);
      chk("wrap_cao_at1", if0.CAO, 1'b0);
      tick();
      chk("wrap_q2", if0.Q, 4'd0);
      chk("wrap_cao_at0", if0.CAO, 1'b1);
      chk("wrap_unf_before", if0.UNF, 1'b0);
      tick();
      chk("wrap_q3", if0.Q, 4'd9);
      chk("wrap_unf_set", if0.UNF, 1'b1);
      chk("wrap_cao_at9", if0.CAO, 1'b0);
      tick();
      chk("wrap_q4", if0.Q, 4'd8);
      chk("wrap_unf_sticky", if0.UNF, 1'b1);

      // Load priority over a pending wrap, then clamping.
      repeat (8) tick();
      chk("pri_q_at0", if0.Q, 4'd0);
      chk("pri_cao_noload", if0.CAO, 1'b1);
      if0.LD = 1'b1; if0.D = 4'd5;
      #1;
      chk("pri_cao_ld", if0.CAO, 1'b0);
      tick();
      chk("pri_q_loaded", if0.Q, 4'd5);
      chk("pri_unf_cleared", if0.UNF, 1'b0);
      if0.D = 4'd12;
      tick();
      chk("clamp_12", if0.Q, 4'd9);
      if0.D = 4'd10;
      tick();
      chk("clamp_10", if0.Q, 4'd9);
      if0.D = 4'd9;
      tick();
      if0.D = 4'd4;
      tick();
      chk("load_4", if0.Q, 4'd4);
      if0.LD = 1'b0;

      // Gating: neither CAI alone nor EN alone steps the counter.
      if0.CAI = 1'b0; if0.EN = 1'b0;
      load0(4'd3);
      if0.CAI = 1'b1; if0.EN = 1'b0;
      repeat (3) begin
         chk("gate_cai_cao", if0.CAO, 1'b0);
         tick();
      end
      chk("gate_cai_q", if0.Q, 4'd3);
      if0.CAI = 1'b0; if0.EN = 1'b1;
      repeat (3) begin
         chk("gate_en_cao", if0.CAO, 1'b0);
         tick();
      end
      chk("gate_en_q", if0.Q, 4'd3);
      load0(4'd0);
      if0.CAI = 1'b1; if0.EN = 1'b0;
      #1;
      chk("gate_cai_cao_q0", if0.CAO, 1'b0);
      tick();
      chk("gate_cai_q0", if0.Q, 4'd0);
      if0.CAI = 1'b0; if0.EN = 1'b1;
      #1;
      chk("gate_en_cao_q0", if0.CAO, 1'b0);
      tick();
      chk("gate_en_q0", if0.Q, 4'd0);
      chk("gate_unf", if0.UNF, 1'b0);

      // Cascade: two decades counting down from 00.
      if0.CAI = 1'b0;
      if0.EN = 1'b1; if1.EN = 1'b1;
      if0.LD = 1'b1; if1.LD = 1'b1;
      if0.D = 4'd0;  if1.D = 4'd0;
      tick();
      if0.LD = 1'b0; if1.LD = 1'b0;
      chk("casc_start", int'(if1.Q) * 10 + int'(if0.Q), 0);
      if0.CAI = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         exp_val = (100 - k) % 100;
         got_val = int'(if1.Q) * 10 + int'(if0.Q);
         chk("casc_value", got_val, exp_val);
      end
      chk("casc_unf1", if1.UNF, 1'b1);
      if0.CAI = 1'b0;

`ifdef CBD_MOD_CNT_UPDN_EN
      // Up-count: 8,9,0,1 then one down step back to 0.
      load0(4'd8);
      if0.UP = 1'b1; if0.CAI = 1'b1; if0.EN = 1'b1;
      #1;
      chk("up_cao_at8", if0.CAO, 1'b0);
      tick();
      chk("up_q9", if0.Q, 4'd9);
      chk("up_cao_at9", if0.CAO, 1'b1);
      chk("up_unf_before", if0.UNF, 1'b0);
      tick();
      chk("up_q0", if0.Q, 4'd0);
      chk("up_unf_set", if0.UNF, 1'b1);
      chk("up_cao_at0", if0.CAO, 1'b0);
      tick();
      chk("up_q1", if0.Q, 4'd1);
      if0.UP = 1'b0;
      tick();
      chk("dn_q0", if0.Q, 4'd0);
      chk("dn_cao_at0", if0.CAO, 1'b1);
      chk("dn_unf_sticky", if0.UNF, 1'b1);
      if0.CAI = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
